// File: rtl/agg_act_packer.sv
// Packs the aggregator's 1-bit activation stream into PACK_W-bit words and
// writes them to the activation buffer at auto-incrementing word addresses.
module agg_act_packer #(
    parameter int PACK_W = 16,
    parameter int ADDR_W = 8,
    localparam int CW    = $clog2(PACK_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              act_valid,
    input  logic              act_in,
    output logic              act_ready,
    input  logic              layer_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [PACK_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CW-1:0]     wr_cnt,
    output logic              busy
);
    localparam int CNT_W = $clog2(PACK_W);

    logic [PACK_W-1:0] pk, pk_acc;
    logic [CNT_W-1:0]  cnt;
    logic [CW-1:0]     cnt_acc;
    logic [ADDR_W-1:0] addr_ptr;
    logic              flush_pend;
    logic              out_free, last, accept, complete;
    logic              flush_req, partial, flush_load, load;

    assign out_free  = !wr_valid || wr_ready;
    assign last      = (cnt == CNT_W'(PACK_W - 1));
    assign act_ready = !layer_start && !flush_pend && (!last || out_free);
    assign accept    = act_valid && act_ready;
    assign complete  = accept && last;

    // Pack register and count as they stand after this cycle's accepted bit.
    always_comb begin
        pk_acc = pk;
        if (accept) pk_acc[cnt] = act_in;
    end
    assign cnt_acc = CW'(cnt) + CW'(accept);

    // A completing bit leaves nothing behind, so a same-cycle flush is a no-op.
    assign flush_req  = (flush || flush_pend) && !layer_start;
    assign partial    = flush_req && !complete && (cnt_acc != '0);
    assign flush_load = partial && out_free;
    assign load       = complete || flush_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pk         <= '0;
            cnt        <= '0;
            addr_ptr   <= '0;
            flush_pend <= 1'b0;
        end else if (layer_start) begin
            pk         <= '0;
            cnt        <= '0;
            addr_ptr   <= base_addr;
            flush_pend <= 1'b0;
        end else if (load) begin
            pk         <= '0;
            cnt        <= '0;
            addr_ptr   <= addr_ptr + ADDR_W'(1);
            flush_pend <= 1'b0;
        end else begin
            pk         <= pk_acc;
            cnt        <= cnt_acc[CNT_W-1:0];
            flush_pend <= partial;
        end
    end

    // One-entry output register; payload only changes on a load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_valid <= 1'b0;
            wr_data  <= '0;
            wr_addr  <= '0;
            wr_cnt   <= '0;
        end else if (load) begin
            wr_valid <= 1'b1;
            wr_data  <= pk_acc;
            wr_addr  <= addr_ptr;
            wr_cnt   <= cnt_acc;
        end else if (wr_ready) begin
            wr_valid <= 1'b0;
        end
    end

    assign busy = (cnt != '0) || wr_valid || flush_pend;

endmodule

// File: tb/tb_agg_act_packer.sv
// Randomised and directed bench for agg_act_packer against a queue-based
// model of the bit stream and expected buffer writes.
module tb_agg_act_packer;
    localparam int PW = 16;

    logic        clk = 0;
    logic        rst = 0;
    logic        act_valid = 0, act_in = 0, layer_start = 0, flush = 0, wr_ready = 1;
    logic [7:0]  base_addr = 0;
    logic        act_ready, wr_valid, busy;
    logic [15:0] wr_data;
    logic [7:0]  wr_addr;
    logic [4:0]  wr_cnt;

    int n_cmp = 0;
    int n_err = 0;

    agg_act_packer #(.PACK_W(16), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .act_valid(act_valid), .act_in(act_in),
        .act_ready(act_ready), .layer_start(layer_start), .base_addr(base_addr),
        .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_cnt(wr_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] d;
        logic [7:0]  a;
        logic [4:0]  c;
    } wr_t;

    bit   bq[$];
    wr_t  exp_q[$];
    logic [7:0] m_addr = 0;
    bit   m_pend = 0, m_occ = 0, m_free;
    wr_t  w;

    task automatic emit();
        wr_t e;
        e.d = 0;
        for (int i = 0; i < bq.size(); i++) if (bq[i]) e.d = e.d + (16'd1 << i);
        e.a = m_addr;
        e.c = 5'(bq.size());
        exp_q.push_back(e);
        m_addr = m_addr + 8'd1;
        bq.delete();
        m_occ = 1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            bq.delete();
            exp_q.delete();
            m_addr = 0;
            m_pend = 0;
            m_occ  = 0;
        end else begin
            m_free = !m_occ || wr_ready;
            check("wr_valid", wr_valid, m_occ);
            check("act_ready", act_ready,
                  !layer_start && !m_pend && (bq.size() != PW - 1 || m_free));
            check("busy", busy, bq.size() != 0 || m_occ || m_pend);
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got %0h@%0h required none", wr_data, wr_addr);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_data", wr_data, w.d);
                    check("wr_addr", wr_addr, w.a);
                    check("wr_cnt", wr_cnt, w.c);
                end
            end
            if (m_occ && wr_ready) m_occ = 0;
            if (layer_start) begin
                bq.delete();
                m_addr = base_addr;
                m_pend = 0;
            end else begin
                if (act_valid && act_ready) begin
                    bq.push_back(act_in);
                    if (bq.size() == PW) emit();
                end
                if (flush || m_pend) begin
                    if (bq.size() == 0) m_pend = 0;
                    else if (m_free) begin
                        emit();
                        m_pend = 0;
                    end else m_pend = 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input logic b);
        int n = 0;
        act_valid = 1;
        act_in    = b;
        forever begin
            @(negedge clk);
            if (act_ready) break;
            n++;
            if (n > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: act_ready got 0 required 1");
                break;
            end
        end
        @(posedge clk); #1;
        act_valid = 0;
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom % 2));
    endtask

    task automatic start_layer(input logic [7:0] b);
        layer_start = 1;
        base_addr   = b;
        @(posedge clk); #1;
        layer_start = 0;
    endtask

    task automatic pulse_flush();
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_valid", wr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_data", wr_data, 0);
        rst = 1;
        @(negedge clk);
        check("out_of_rst_ready", act_ready, 1);
        @(posedge clk); #1;

        // 1: alternating bits -> 0x5555 @0x10
        start_layer(8'h10);
        for (int i = 0; i < 16; i++) send_bit((i % 2) == 0);
        @(negedge clk);
        check("t1_valid", wr_valid, 1);
        check("t1_data", wr_data, 16'h5555);
        check("t1_addr", wr_addr, 8'h10);
        check("t1_cnt", wr_cnt, 16);
        @(posedge clk); #1;

        // 2: backpressure, 32 ones
        start_layer(8'h10);
        wr_ready = 0;
        for (int i = 0; i < 31; i++) send_bit(1);
        act_valid = 1;
        act_in    = 1;
        @(negedge clk);
        check("t2_blocked", act_ready, 0);
        check("t2_held_data", wr_data, 16'hFFFF);
        check("t2_held_addr", wr_addr, 8'h10);
        @(posedge clk); #1;
        wr_ready = 1;
        @(negedge clk);
        check("t2_ready_again", act_ready, 1);
        check("t2_w0_addr", wr_addr, 8'h10);
        @(posedge clk); #1;
        act_valid = 0;
        @(negedge clk);
        check("t2_w1_valid", wr_valid, 1);
        check("t2_w1_data", wr_data, 16'hFFFF);
        check("t2_w1_addr", wr_addr, 8'h11);
        @(posedge clk); #1;

        // 3: partial flush 1,1,0,1,1 -> 0x001B, cnt 5
        start_layer(8'h10);
        send_bit(1); send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        pulse_flush();
        @(negedge clk);
        check("t3_valid", wr_valid, 1);
        check("t3_data", wr_data, 16'h001B);
        check("t3_cnt", wr_cnt, 5);
        check("t3_addr", wr_addr, 8'h10);
        @(posedge clk); #1;
        send_rand(16);
        @(negedge clk);
        check("t3_next_addr", wr_addr, 8'h11);
        @(posedge clk); #1;

        // 4: address wrap
        start_layer(8'hFF);
        send_rand(16);
        @(negedge clk);
        check("t4_addr_ff", wr_addr, 8'hFF);
        @(posedge clk); #1;
        send_rand(16);
        @(negedge clk);
        check("t4_addr_wrap", wr_addr, 8'h00);
        @(posedge clk); #1;

        // 5: layer_start discards partial; flush at cnt 0 is a no-op
        start_layer(8'h20);
        send_rand(7);
        start_layer(8'h40);
        @(negedge clk);
        check("t5_no_write", wr_valid, 0);
        check("t5_idle", busy, 0);
        @(posedge clk); #1;
        send_rand(16);
        @(negedge clk);
        check("t5_addr", wr_addr, 8'h40);
        @(posedge clk); #1;
        pulse_flush();
        @(negedge clk);
        check("t5_flush_noop", wr_valid, 0);
        @(posedge clk); #1;

        // 6: async reset while a word is held
        wr_ready = 0;
        send_rand(16);
        @(negedge clk);
        check("t6_held", wr_valid, 1);
        @(posedge clk); #3;
        rst = 0;
        #1;
        check("t6_async_valid", wr_valid, 0);
        check("t6_async_data", wr_data, 0);
        check("t6_async_addr", wr_addr, 0);
        check("t6_async_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        wr_ready = 1;
        @(negedge clk);
        check("t6_ready", act_ready, 1);
        check("t6_busy", busy, 0);
        @(posedge clk); #1;
        send_rand(16);
        @(negedge clk);
        check("t6_addr0", wr_addr, 8'h00);
        @(posedge clk); #1;

        // randomised traffic
        for (int i = 0; i < 4000; i++) begin
            act_valid   = ($urandom % 4) != 0;
            act_in      = 1'($urandom % 2);
            wr_ready    = ($urandom % 3) != 0;
            flush       = ($urandom % 20) == 0;
            layer_start = ($urandom % 60) == 0;
            base_addr   = 8'($urandom);
            @(posedge clk); #1;
        end
        act_valid = 0; flush = 0; layer_start = 0; wr_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        pulse_flush();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drain_queue", exp_q.size(), 0);
        check("drain_valid", wr_valid, 0);
        check("drain_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
